// File: rtl/flash_audio_streamer.sv
// Strobe-driven flash reader: fetches one 2*SAMPLE_W word per pair of samples and walks an address window.
// Define FLASH_STREAM_LOOP_EN to wrap at the window edges instead of stopping with at_end.
module flash_audio_streamer #(
  parameter int                ADDR_W     = 23,
  parameter int                SAMPLE_W   = 16,
  parameter logic [ADDR_W-1:0] START_ADDR = '0,
  parameter logic [ADDR_W-1:0] END_ADDR   = 23'h7FFFF
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic                    sample_strobe,
  input  logic                    pause,
  input  logic                    direction,
  input  logic                    restart,
  output logic                    flash_mem_read,
  output logic [ADDR_W-1:0]       flash_mem_address,
  output logic [2*SAMPLE_W/8-1:0] flash_mem_byteenable,
  input  logic                    flash_mem_waitrequest,
  input  logic [2*SAMPLE_W-1:0]   flash_mem_readdata,
  input  logic                    flash_mem_readdatavalid,
  output logic [SAMPLE_W-1:0]     sample_out,
  output logic                    sample_valid,
  output logic                    at_end,
  output logic                    underrun
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT_DATA} state_t;

  state_t              r_state;
  logic [ADDR_W-1:0]   r_addr;
  logic [SAMPLE_W-1:0] r_sample;
  logic [SAMPLE_W-1:0] r_pendHalf;
  logic                r_read;
  logic                r_valid;
  logic                r_pending;
  logic                r_atEnd;
  logic                r_endDir;
  logic                r_underrun;
  logic                r_restartPend;

  logic                w_strobeLive;
  logic                w_accept;
  logic [ADDR_W-1:0]   w_restartAddr;
  logic [ADDR_W-1:0]   w_nextAddr;
  logic                w_hitEnd;
  logic [SAMPLE_W-1:0] w_lo;
  logic [SAMPLE_W-1:0] w_hi;

  assign w_strobeLive  = sample_strobe & ~pause;
  assign w_accept      = w_strobeLive & ~r_atEnd;
  assign w_restartAddr = direction ? START_ADDR : END_ADDR;
  assign w_lo          = flash_mem_readdata[SAMPLE_W-1:0];
  assign w_hi          = flash_mem_readdata[2*SAMPLE_W-1:SAMPLE_W];

  // Edges are detected by equality, so stepping off either end never relies on natural wrap.
  always_comb begin
    w_nextAddr = r_addr;
    w_hitEnd   = 1'b0;
    if (direction) begin
      if (r_addr == END_ADDR) begin
`ifdef FLASH_STREAM_LOOP_EN
        w_nextAddr = START_ADDR;
`else
        w_hitEnd   = 1'b1;
`endif
      end else begin
        w_nextAddr = r_addr + ADDR_W'(1);
      end
    end else begin
      if (r_addr == START_ADDR) begin
`ifdef FLASH_STREAM_LOOP_EN
        w_nextAddr = END_ADDR;
`else
        w_hitEnd   = 1'b1;
`endif
      end else begin
        w_nextAddr = r_addr - ADDR_W'(1);
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state       <= IDLE;
      r_addr        <= START_ADDR;
      r_sample      <= '0;
      r_pendHalf    <= '0;
      r_read        <= 1'b0;
      r_valid       <= 1'b0;
      r_pending     <= 1'b0;
      r_atEnd       <= 1'b0;
      r_endDir      <= 1'b0;
      r_underrun    <= 1'b0;
      r_restartPend <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      case (r_state)
        IDLE: begin
          if (restart) begin
            r_addr     <= w_restartAddr;
            r_pending  <= 1'b0;
            r_atEnd    <= 1'b0;
            r_underrun <= 1'b0;
          end else begin
            if (r_atEnd && (direction != r_endDir)) r_atEnd <= 1'b0;
            if (w_accept) begin
              if (r_pending) begin
                r_sample  <= r_pendHalf;
                r_valid   <= 1'b1;
                r_pending <= 1'b0;
                r_addr    <= w_nextAddr;
                if (w_hitEnd) begin
                  r_atEnd  <= 1'b1;
                  r_endDir <= direction;
                end
              end else begin
                r_read  <= 1'b1;
                r_state <= REQ;
              end
            end
          end
        end
        REQ: begin
          if (restart)      r_restartPend <= 1'b1;
          if (w_strobeLive) r_underrun    <= 1'b1;
          if (!flash_mem_waitrequest) begin
            r_read  <= 1'b0;
            r_state <= WAIT_DATA;
          end
        end
        WAIT_DATA: begin
          if (restart)      r_restartPend <= 1'b1;
          if (w_strobeLive) r_underrun    <= 1'b1;
          if (flash_mem_readdatavalid) begin
            r_state <= IDLE;
            // A restart requested during the fetch swallows the returned word.
            if (r_restartPend || restart) begin
              r_restartPend <= 1'b0;
              r_addr        <= w_restartAddr;
              r_pending     <= 1'b0;
              r_atEnd       <= 1'b0;
              r_underrun    <= 1'b0;
            end else begin
              r_sample   <= direction ? w_lo : w_hi;
              r_pendHalf <= direction ? w_hi : w_lo;
              r_pending  <= 1'b1;
              r_valid    <= 1'b1;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign flash_mem_read       = r_read;
  assign flash_mem_address    = r_addr;
  assign flash_mem_byteenable = '1;
  assign sample_out           = r_sample;
  assign sample_valid         = r_valid;
  assign at_end               = r_atEnd;
  assign underrun             = r_underrun;

endmodule

// File: tb/tb_flash_audio_streamer.sv
// Bench for flash_audio_streamer: a small flash slave plus a sample-stream model over a 4-word window.
// Boundary expectations follow FLASH_STREAM_LOOP_EN when it is defined.
module tb_flash_audio_streamer;

  localparam logic [22:0] S = 23'h10;
  localparam logic [22:0] E = 23'h13;

  logic        clock = 1'b0;
  logic        reset_n = 1'b1;
  logic        sample_strobe = 1'b0;
  logic        pause = 1'b0;
  logic        direction = 1'b1;
  logic        restart = 1'b0;
  logic        flash_mem_waitrequest = 1'b0;
  logic [31:0] flash_mem_readdata = '0;
  logic        flash_mem_readdatavalid = 1'b0;
  logic        flash_mem_read;
  logic [22:0] flash_mem_address;
  logic [3:0]  flash_mem_byteenable;
  logic [15:0] sample_out;
  logic        sample_valid;
  logic        at_end;
  logic        underrun;

  flash_audio_streamer #(
    .ADDR_W(23), .SAMPLE_W(16), .START_ADDR(S), .END_ADDR(E)
  ) dut (
    .clock(clock), .reset_n(reset_n), .sample_strobe(sample_strobe), .pause(pause),
    .direction(direction), .restart(restart), .flash_mem_read(flash_mem_read),
    .flash_mem_address(flash_mem_address), .flash_mem_byteenable(flash_mem_byteenable),
    .flash_mem_waitrequest(flash_mem_waitrequest), .flash_mem_readdata(flash_mem_readdata),
    .flash_mem_readdatavalid(flash_mem_readdatavalid), .sample_out(sample_out),
    .sample_valid(sample_valid), .at_end(at_end), .underrun(underrun)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;
  int readStarts = 0;
  int readHighCnt = 0;
  int validCount = 0;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, actual, expected, $time);
    end
  endtask

  // Flash contents: the two window edges hold the reference word, the rest a tagged pattern.
  function automatic logic [31:0] memWord(input logic [22:0] a);
    logic [7:0] t;
    t = a[7:0];
    if (a == S || a == E) return 32'hBEEF_1234;
    return {8'hA0, t, 8'h50, t};
  endfunction

  // Stream model: position in the window, pending half, end/underrun flags, expected samples.
  logic [22:0] mAddr;
  logic [15:0] mHalf;
  bit          mPending, mAtEnd, mEndDir, mUnderrun;
  logic [15:0] expQ[$];

  function automatic void modelReset();
    mAddr = S; mHalf = '0; mPending = 0; mAtEnd = 0; mEndDir = 0; mUnderrun = 0;
    expQ.delete();
  endfunction

  function automatic void modelRestart(input bit d);
    mAddr = d ? S : E; mPending = 0; mAtEnd = 0; mUnderrun = 0;
  endfunction

  function automatic void modelAdvance(input bit d);
    if (d) begin
      if (mAddr == E) begin
`ifdef FLASH_STREAM_LOOP_EN
        mAddr = S;
`else
        mAtEnd = 1; mEndDir = 1;
`endif
      end else mAddr = mAddr + 23'd1;
    end else begin
      if (mAddr == S) begin
`ifdef FLASH_STREAM_LOOP_EN
        mAddr = E;
`else
        mAtEnd = 1; mEndDir = 0;
`endif
      end else mAddr = mAddr - 23'd1;
    end
  endfunction

  function automatic void modelAccept(input bit d);
    logic [31:0] w;
    if (mAtEnd) return;
    if (mPending) begin
      expQ.push_back(mHalf);
      mPending = 0;
      modelAdvance(d);
    end else begin
      w = memWord(mAddr);
      expQ.push_back(d ? w[15:0] : w[31:16]);
      mHalf = d ? w[31:16] : w[15:0];
      mPending = 1;
    end
  endfunction

  // Avalon slave: cfgWait stall cycles, then readdatavalid cfgLat cycles after acceptance.
  int cfgWait = 0;
  int cfgLat = 1;
  int svState = 0;
  int svCnt = 0;
  logic [22:0] svAddr = '0;

  initial begin
    forever begin
      @(negedge clock);
      if (!reset_n) begin
        svState = 0; flash_mem_waitrequest = 0; flash_mem_readdatavalid = 0;
      end else begin
        case (svState)
          0: if (flash_mem_read) begin
               svAddr = flash_mem_address;
               svCnt = cfgWait;
               flash_mem_waitrequest = (svCnt > 0);
               svState = 1;
             end
          1: if (!flash_mem_waitrequest) begin
               svCnt = cfgLat - 1;
               svState = 2;
               if (svCnt == 0) begin
                 flash_mem_readdatavalid = 1; flash_mem_readdata = memWord(svAddr);
               end
             end else begin
               svCnt--;
               flash_mem_waitrequest = (svCnt > 0);
             end
          default: if (flash_mem_readdatavalid) begin
               flash_mem_readdatavalid = 0; svState = 0;
             end else begin
               svCnt--;
               if (svCnt == 0) begin
                 flash_mem_readdatavalid = 1; flash_mem_readdata = memWord(svAddr);
               end
             end
        endcase
      end
    end
  end

  // Per-cycle compare: every sample_valid must match the next modelled sample; address holds during a read.
  initial begin
    logic        prevRead;
    logic [22:0] prevAddr;
    logic [15:0] e;
    prevRead = 0; prevAddr = '0;
    forever begin
      @(negedge clock);
      if (!reset_n) begin
        prevRead = 0;
        continue;
      end
      if (sample_valid) begin
        validCount++;
        if (expQ.size() == 0) checkOutput("spurious_valid", {31'b0, sample_valid}, 32'd0);
        else begin
          e = expQ.pop_front();
          checkOutput("sample", {16'b0, sample_out}, {16'b0, e});
        end
      end
      if (flash_mem_read) readHighCnt++;
      if (flash_mem_read && !prevRead) readStarts++;
      if (flash_mem_read && prevRead) checkOutput("addr_stable", {9'b0, flash_mem_address}, {9'b0, prevAddr});
      prevRead = flash_mem_read;
      prevAddr = flash_mem_address;
    end
  end

  task automatic pulseStrobe();
    @(negedge clock); sample_strobe = 1;
    @(negedge clock); sample_strobe = 0;
  endtask

  task automatic applyStimulus(input bit predicted);
    if (predicted) modelAccept(direction);
    pulseStrobe();
  endtask

  task automatic restartPulse();
    @(negedge clock); restart = 1;
    @(negedge clock); restart = 0;
    modelRestart(direction);
  endtask

  task automatic setDir(input bit d);
    @(negedge clock); direction = d;
    if (mAtEnd && d != mEndDir) mAtEnd = 0;
    @(negedge clock);
  endtask

  task automatic waitIdle();
    bit done;
    done = 0;
    for (int i = 0; i < 64 && !done; i++) begin
      @(negedge clock); #1;
      if (expQ.size() == 0 && !flash_mem_read && svState == 0) done = 1;
    end
    if (!done) begin
      checkOutput("wait_idle_timeout", {31'b0, flash_mem_read}, 32'd0);
      expQ.delete();
    end
    checkOutput("model_addr", {9'b0, flash_mem_address}, {9'b0, mAddr});
    checkOutput("model_at_end", {31'b0, at_end}, {31'b0, mAtEnd});
    checkOutput("model_underrun", {31'b0, underrun}, {31'b0, mUnderrun});
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int rs, vc;
    modelReset();
    #1 reset_n = 0;
    #1;
    checkOutput("rst_read", {31'b0, flash_mem_read}, 32'd0);
    checkOutput("rst_addr", {9'b0, flash_mem_address}, {9'b0, S});
    checkOutput("rst_sample", {16'b0, sample_out}, 32'd0);
    checkOutput("rst_valid", {31'b0, sample_valid}, 32'd0);
    checkOutput("rst_at_end", {31'b0, at_end}, 32'd0);
    checkOutput("rst_underrun", {31'b0, underrun}, 32'd0);
    checkOutput("byteenable", {28'b0, flash_mem_byteenable}, 32'hF);
    repeat (2) @(negedge clock);
    reset_n = 1;

    // Forward: low half first, then high half; address steps once both are out.
    applyStimulus(1);
    checkOutput("fetch_read_latency", {31'b0, flash_mem_read}, 32'd1);
    waitIdle();
    checkOutput("fwd_first", {16'b0, sample_out}, 32'h1234);
    applyStimulus(1);
    checkOutput("pending_valid_latency", {31'b0, sample_valid}, 32'd1);
    checkOutput("fwd_second", {16'b0, sample_out}, 32'hBEEF);
    waitIdle();
    checkOutput("fwd_addr", {9'b0, flash_mem_address}, 32'h11);

    // Walk to the far edge of the window.
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1);
      waitIdle();
    end
`ifdef FLASH_STREAM_LOOP_EN
    checkOutput("wrap_addr", {9'b0, flash_mem_address}, 32'h10);
    applyStimulus(1);
    waitIdle();
    checkOutput("wrap_read_addr", {9'b0, svAddr}, 32'h10);
    applyStimulus(1);
    waitIdle();
`else
    checkOutput("end_at_end", {31'b0, at_end}, 32'd1);
    checkOutput("end_addr", {9'b0, flash_mem_address}, 32'h13);
    rs = readStarts;
    applyStimulus(1);
    waitIdle();
    applyStimulus(1);
    waitIdle();
    checkOutput("end_no_reads", rs, readStarts);
    checkOutput("end_no_underrun", {31'b0, underrun}, 32'd0);
`endif

    // Turning around resumes from the boundary word (upper half first going backward).
    setDir(0);
    applyStimulus(1);
    waitIdle();
`ifndef FLASH_STREAM_LOOP_EN
    checkOutput("turnaround_sample", {16'b0, sample_out}, 32'hBEEF);
`endif

    // Backward from the end of the window.
    restartPulse();
    checkOutput("bwd_restart_addr", {9'b0, flash_mem_address}, 32'h13);
    applyStimulus(1);
    waitIdle();
    checkOutput("bwd_first", {16'b0, sample_out}, 32'hBEEF);
    applyStimulus(1);
    waitIdle();
    checkOutput("bwd_second", {16'b0, sample_out}, 32'h1234);
    checkOutput("bwd_addr", {9'b0, flash_mem_address}, 32'h12);

    // Stalled slave with a strobe landing mid-stall.
    setDir(1);
    restartPulse();
    cfgWait = 5; cfgLat = 3;
    readHighCnt = 0; vc = validCount;
    applyStimulus(1);
    applyStimulus(0);
    mUnderrun = 1;
    waitIdle();
    checkOutput("stall_read_cycles", readHighCnt, 6);
    checkOutput("stall_valid_count", validCount - vc, 1);
    checkOutput("stall_underrun", {31'b0, underrun}, 32'd1);
    checkOutput("stall_sample", {16'b0, sample_out}, 32'h1234);

    // Restart while the word is in flight: data discarded, underrun cleared.
    restartPulse();
    cfgWait = 0; cfgLat = 4;
    vc = validCount;
    applyStimulus(0);
    applyStimulus(0);
    checkOutput("busy_underrun", {31'b0, underrun}, 32'd1);
    restartPulse();
    waitIdle();
    checkOutput("restart_no_valid", validCount - vc, 0);
    checkOutput("restart_underrun", {31'b0, underrun}, 32'd0);
    applyStimulus(1);
    waitIdle();
    checkOutput("restart_read_addr", {9'b0, svAddr}, 32'h10);

    // Paused strobes do nothing.
    @(negedge clock); pause = 1;
    rs = readStarts; vc = validCount;
    for (int i = 0; i < 4; i++) applyStimulus(0);
    repeat (3) @(negedge clock);
    checkOutput("pause_no_reads", readStarts - rs, 0);
    checkOutput("pause_no_valid", validCount - vc, 0);
    checkOutput("pause_underrun", {31'b0, underrun}, 32'd0);
    pause = 0;

    // Asynchronous reset in the middle of a stalled read.
    applyStimulus(1);
    waitIdle();
    cfgWait = 5;
    applyStimulus(0);
    checkOutput("pre_reset_read", {31'b0, flash_mem_read}, 32'd1);
    #2 reset_n = 0;
    #1;
    checkOutput("async_rst_read", {31'b0, flash_mem_read}, 32'd0);
    checkOutput("async_rst_addr", {9'b0, flash_mem_address}, 32'h10);
    checkOutput("async_rst_sample", {16'b0, sample_out}, 32'd0);
    modelReset();
    repeat (2) @(negedge clock);
    reset_n = 1;
    cfgWait = 0; cfgLat = 1;
    applyStimulus(1);
    waitIdle();
    checkOutput("post_reset_sample", {16'b0, sample_out}, 32'h1234);

    repeat (3) @(negedge clock);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
